lime_control_fsm: RTL and testbench

- Multi-cycle control unit for the 16-bit Lime processor.
- Decodes the 7-bit IR control field and sequences the FetchAndMemory, Data and Calculations blocks through fetch, decode, execute, memory and writeback cycles.
- Generates every datapath control strobe and mux select, stalls on memory handshake, and tracks retired instructions and halt/illegal status.

---
 rtl/lime_control_fsm.sv | 239 +++++++++++++++++++++++
 tb/tb_lime_control_fsm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lime_control_fsm.sv
// ----------------------------------------------------------------------------
// lime_control_fsm
//
// Multi-cycle control unit for the 16-bit Lime processor. It decodes the IR
// control field and steps the FetchAndMemory, Data and Calculations blocks
// through the fetch / decode / execute / memory / writeback cycles. It stalls
// on the memory handshake, counts retired instructions and reports halt and
// illegal-opcode status.
//
// Ports
//   CLK              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   input_opcode     IR control field; class is opcode[6:4]
//   input_mem_ready  memory access completes this cycle
//   PCWrite          PC load enable
//   IRWrite          IR/MDR load enable
//   IorD             memory address source (0 = PC, 1 = ALUOut)
//   memR / memW      memory read / write request
//   mem2reg          register write data source (0 = ALUOut, 1 = MDR)
//   regWrite         register file write enable
//   ALUSrcA          ALU A select (00 PC, 01 reg A, 10 zero)
//   ALUSrcB          ALU B select (00 reg B, 01 const 1, 10 imm, 11 zero)
//   ALUOp            ALU operation (000 ADD, 001 SUB, else opcode[2:0])
//   PCSrc            next-PC source (0 ALU result, 1 ALUOut)
//   branch           conditional-branch qualifier to the fetch unit
//   branchType       branch condition (opcode[1:0])
//   halted           core stopped
//   illegal          sticky: halt was caused by a reserved opcode
//   state_dbg        current state encoding
//   retired          instructions completed, wraps modulo 2^CNTW
// ----------------------------------------------------------------------------
module lime_control_fsm #(
   parameter int OPW  = 7,
   parameter int CNTW = 16
) (
   input  logic            CLK,
   input  logic            rst_n,
   input  logic [OPW-1:0]  input_opcode,
   input  logic            input_mem_ready,
   output logic            PCWrite,
   output logic            IRWrite,
   output logic            IorD,
   output logic            memR,
   output logic            memW,
   output logic            mem2reg,
   output logic            regWrite,
   output logic [1:0]      ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [2:0]      ALUOp,
   output logic            PCSrc,
   output logic            branch,
   output logic [1:0]      branchType,
   output logic            halted,
   output logic            illegal,
   output logic [3:0]      state_dbg,
   output logic [CNTW-1:0] retired
);

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_EXEC_I   = 4'd3,
      ST_MEM_ADDR = 4'd4,
      ST_MEM_RD   = 4'd5,
      ST_MEM_WB   = 4'd6,
      ST_MEM_WR   = 4'd7,
      ST_ALU_WB   = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JUMP     = 4'd10,
      ST_HALT     = 4'd11
   } state_t;

   // ir_arm / pc_arm mark states whose IRWrite / PCWrite must wait for the
   // memory handshake; they are qualified with input_mem_ready at the port.
   typedef struct packed {
      logic       mem_r;
      logic       mem_w;
      logic       ior_d;
      logic       mem2reg;
      logic       reg_write;
      logic       pc_write;
      logic       ir_arm;
      logic       pc_arm;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [2:0] alu_op;
      logic       pc_src;
      logic       branch;
      logic [1:0] branch_type;
      logic       halted;
   } ctrl_t;

   state_t          state;
   state_t          next_state;
   ctrl_t           ctrl_q;
   logic            illegal_q;
   logic [CNTW-1:0] retired_q;
   logic [2:0]      op_class;
   logic [2:0]      op_fn;
   logic            opcode_unused;

   assign op_class      = input_opcode[6:4];
   assign op_fn         = input_opcode[2:0];
   assign opcode_unused = input_opcode[3];

   // Moore control word for a given state. Evaluated on the next state so
   // the outputs are registered yet line up with the state they belong to.
   function automatic ctrl_t decode_ctrl(input state_t s, input logic [2:0] fn);
      ctrl_t c;
      c = '0;
      case (s)
         ST_FETCH: begin
            c.mem_r  = 1'b1;
            c.src_b  = 2'b01;
            c.ir_arm = 1'b1;
            c.pc_arm = 1'b1;
         end
         ST_DECODE: begin
            c.src_b = 2'b10;
         end
         ST_EXEC_R: begin
            c.src_a  = 2'b01;
            c.alu_op = fn;
         end
         ST_EXEC_I: begin
            c.src_a  = 2'b01;
            c.src_b  = 2'b10;
            c.alu_op = fn;
         end
         ST_MEM_ADDR: begin
            c.src_a = 2'b01;
            c.src_b = 2'b10;
         end
         ST_MEM_RD: begin
            c.mem_r  = 1'b1;
            c.ior_d  = 1'b1;
            c.ir_arm = 1'b1;
         end
         ST_MEM_WB: begin
            c.reg_write = 1'b1;
            c.mem2reg   = 1'b1;
         end
         ST_MEM_WR: begin
            c.mem_w = 1'b1;
            c.ior_d = 1'b1;
         end
         ST_ALU_WB: begin
            c.reg_write = 1'b1;
         end
         ST_BRANCH: begin
            c.src_a       = 2'b01;
            c.alu_op      = 3'b001;
            c.branch      = 1'b1;
            c.branch_type = fn[1:0];
            c.pc_src      = 1'b1;
         end
         ST_JUMP: begin
            c.pc_src   = 1'b1;
            c.pc_write = 1'b1;
         end
         ST_HALT: begin
            c.halted = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   // Next-state selection. Memory states hold until the handshake; the
   // unused codes 12-15 fall back to FETCH.
   always_comb begin
      next_state = state;
      case (state)
         ST_FETCH:    if (input_mem_ready) next_state = ST_DECODE;
         ST_DECODE: begin
            case (op_class)
               3'b000:         next_state = ST_EXEC_R;
               3'b001:         next_state = ST_EXEC_I;
               3'b010, 3'b011: next_state = ST_MEM_ADDR;
               3'b100:         next_state = ST_BRANCH;
               3'b101:         next_state = ST_JUMP;
               default:        next_state = ST_HALT;
            endcase
         end
         ST_EXEC_R,
         ST_EXEC_I:   next_state = ST_ALU_WB;
         ST_MEM_ADDR: next_state = op_class[0] ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD:   if (input_mem_ready) next_state = ST_MEM_WB;
         ST_MEM_WR:   if (input_mem_ready) next_state = ST_FETCH;
         ST_ALU_WB,
         ST_MEM_WB,
         ST_BRANCH,
         ST_JUMP:     next_state = ST_FETCH;
         ST_HALT:     next_state = ST_HALT;
         default:     next_state = ST_FETCH;
      endcase
   end

   // State, registered control word, sticky illegal flag and retire counter.
   // Reset loads the FETCH control word so the first fetch request is ready
   // as soon as reset is released.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_FETCH;
         ctrl_q    <= decode_ctrl(ST_FETCH, 3'b000);
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state  <= next_state;
         ctrl_q <= decode_ctrl(next_state, op_fn);
         if (state == ST_DECODE && op_class == 3'b110)
            illegal_q <= 1'b1;
         if (next_state == ST_FETCH && state != ST_FETCH)
            retired_q <= retired_q + CNTW'(1);
      end
   end

   // Strobes are gated with rst_n so they drop the moment reset asserts,
   // even while the reset value of the control word is the FETCH word.
   assign PCWrite    = (ctrl_q.pc_write | (ctrl_q.pc_arm & input_mem_ready)) & rst_n;
   assign IRWrite    = ctrl_q.ir_arm & input_mem_ready & rst_n;
   assign memR       = ctrl_q.mem_r & rst_n;
   assign memW       = ctrl_q.mem_w & rst_n;
   assign regWrite   = ctrl_q.reg_write & rst_n;
   assign branch     = ctrl_q.branch & rst_n;
   assign IorD       = ctrl_q.ior_d;
   assign mem2reg    = ctrl_q.mem2reg;
   assign ALUSrcA    = ctrl_q.src_a;
   assign ALUSrcB    = ctrl_q.src_b;
   assign ALUOp      = ctrl_q.alu_op;
   assign PCSrc      = ctrl_q.pc_src;
   assign branchType = ctrl_q.branch_type;
   assign halted     = ctrl_q.halted;
   assign illegal    = illegal_q;
   assign state_dbg  = state;
   assign retired    = retired_q;

endmodule

// File: tb/tb_lime_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_lime_control_fsm
//
// Directed bench for lime_control_fsm. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge. Expected
// values are hand-derived per cycle from the instruction sequencing.
// Strobe vector order: {PCWrite, IRWrite, IorD, memR, memW, mem2reg,
// regWrite, branch}.
// ----------------------------------------------------------------------------
module tb_lime_control_fsm;

   localparam logic [6:0] OP_SUB   = 7'b0000001;
   localparam logic [6:0] OP_LOAD  = 7'b0100000;
   localparam logic [6:0] OP_STORE = 7'b0110000;
   localparam logic [6:0] OP_BR    = 7'b1000010;
   localparam logic [6:0] OP_JUMP  = 7'b1010000;
   localparam logic [6:0] OP_RSVD  = 7'b1100000;

   logic        CLK;
   logic        rst_n;
   logic [6:0]  input_opcode;
   logic        input_mem_ready;
   logic        PCWrite, IRWrite, IorD, memR, memW, mem2reg, regWrite;
   logic [1:0]  ALUSrcA, ALUSrcB;
   logic [2:0]  ALUOp;
   logic        PCSrc, branch;
   logic [1:0]  branchType;
   logic        halted, illegal;
   logic [3:0]  state_dbg;
   logic [15:0] retired;
   logic [7:0]  strobes;

   int checks   = 0;
   int failures = 0;

   lime_control_fsm #(.OPW(7), .CNTW(16)) dut (
      .CLK             (CLK),
      .rst_n           (rst_n),
      .input_opcode    (input_opcode),
      .input_mem_ready (input_mem_ready),
      .PCWrite         (PCWrite),
      .IRWrite         (IRWrite),
      .IorD            (IorD),
      .memR            (memR),
      .memW            (memW),
      .mem2reg         (mem2reg),
      .regWrite        (regWrite),
      .ALUSrcA         (ALUSrcA),
      .ALUSrcB         (ALUSrcB),
      .ALUOp           (ALUOp),
      .PCSrc           (PCSrc),
      .branch          (branch),
      .branchType      (branchType),
      .halted          (halted),
      .illegal         (illegal),
      .state_dbg       (state_dbg),
      .retired         (retired)
   );

   assign strobes = {PCWrite, IRWrite, IorD, memR, memW, mem2reg, regWrite, branch};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance to the next falling edge, drive the inputs for that cycle and
   // let combinational outputs settle before sampling.
   task automatic applyStimulus(input logic [6:0] op, input logic rdy);
      @(negedge CLK);
      input_opcode    = op;
      input_mem_ready = rdy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkCycle(input string tag, input logic [3:0] st, input logic [7:0] stb);
      checkOutput({tag, "_state"}, 32'(state_dbg), 32'(st));
      checkOutput({tag, "_strobes"}, 32'(strobes), 32'(stb));
   endtask

   initial begin
      rst_n           = 1'b0;
      input_opcode    = '0;
      input_mem_ready = 1'b1;
      repeat (2) @(negedge CLK);
      #1;
      $display("[TB] reset state");
      checkCycle("reset", 4'd0, 8'b0000_0000);
      checkOutput("reset_retired", 32'(retired), 32'd0);
      checkOutput("reset_halted", 32'(halted), 32'd0);
      checkOutput("reset_illegal", 32'(illegal), 32'd0);

      // R-ALU SUB: FETCH, DECODE, EXEC_R, ALU_WB, FETCH
      $display("[TB] R-ALU SUB");
      @(negedge CLK);
      rst_n           = 1'b1;
      input_opcode    = OP_SUB;
      input_mem_ready = 1'b1;
      #1;
      checkCycle("sub_fetch", 4'd0, 8'b1101_0000);
      checkOutput("sub_fetch_srcb", 32'(ALUSrcB), 32'd1);
      applyStimulus(OP_SUB, 1'b1);
      checkCycle("sub_decode", 4'd1, 8'b0000_0000);
      checkOutput("sub_decode_srcb", 32'(ALUSrcB), 32'd2);
      applyStimulus(OP_SUB, 1'b1);
      checkCycle("sub_exec", 4'd2, 8'b0000_0000);
      checkOutput("sub_exec_aluop", 32'(ALUOp), 32'd1);
      checkOutput("sub_exec_srca", 32'(ALUSrcA), 32'd1);
      applyStimulus(OP_SUB, 1'b1);
      checkCycle("sub_wb", 4'd8, 8'b0000_0010);
      checkOutput("sub_wb_retired", 32'(retired), 32'd0);

      // LOAD with two wait cycles in MEM_RD
      $display("[TB] LOAD with wait");
      applyStimulus(OP_LOAD, 1'b1);
      checkCycle("ld_fetch", 4'd0, 8'b1101_0000);
      checkOutput("sub_retired", 32'(retired), 32'd1);
      applyStimulus(OP_LOAD, 1'b0);
      checkCycle("ld_decode", 4'd1, 8'b0000_0000);
      applyStimulus(OP_LOAD, 1'b0);
      checkCycle("ld_addr", 4'd4, 8'b0000_0000);
      checkOutput("ld_addr_srcb", 32'(ALUSrcB), 32'd2);
      applyStimulus(OP_LOAD, 1'b0);
      checkCycle("ld_wait1", 4'd5, 8'b0011_0000);
      applyStimulus(OP_LOAD, 1'b0);
      checkCycle("ld_wait2", 4'd5, 8'b0011_0000);
      applyStimulus(OP_LOAD, 1'b1);
      checkCycle("ld_rd", 4'd5, 8'b0111_0000);
      applyStimulus(OP_LOAD, 1'b1);
      checkCycle("ld_wb", 4'd6, 8'b0000_0110);

      // STORE then BRANCH
      $display("[TB] STORE then BRANCH");
      applyStimulus(OP_STORE, 1'b1);
      checkCycle("st_fetch", 4'd0, 8'b1101_0000);
      checkOutput("ld_retired", 32'(retired), 32'd2);
      applyStimulus(OP_STORE, 1'b1);
      checkCycle("st_decode", 4'd1, 8'b0000_0000);
      applyStimulus(OP_STORE, 1'b1);
      checkCycle("st_addr", 4'd4, 8'b0000_0000);
      applyStimulus(OP_STORE, 1'b1);
      checkCycle("st_wr", 4'd7, 8'b0010_1000);
      applyStimulus(OP_BR, 1'b1);
      checkCycle("br_fetch", 4'd0, 8'b1101_0000);
      checkOutput("st_retired", 32'(retired), 32'd3);
      applyStimulus(OP_BR, 1'b1);
      checkCycle("br_decode", 4'd1, 8'b0000_0000);
      applyStimulus(OP_BR, 1'b1);
      checkCycle("br_exec", 4'd9, 8'b0000_0001);
      checkOutput("br_type", 32'(branchType), 32'd2);
      checkOutput("br_aluop", 32'(ALUOp), 32'd1);
      checkOutput("br_pcsrc", 32'(PCSrc), 32'd1);

      // JUMP
      $display("[TB] JUMP");
      applyStimulus(OP_JUMP, 1'b1);
      checkCycle("jmp_fetch", 4'd0, 8'b1101_0000);
      checkOutput("br_retired", 32'(retired), 32'd4);
      applyStimulus(OP_JUMP, 1'b1);
      checkCycle("jmp_decode", 4'd1, 8'b0000_0000);
      applyStimulus(OP_JUMP, 1'b1);
      checkCycle("jmp_exec", 4'd10, 8'b1000_0000);
      checkOutput("jmp_pcsrc", 32'(PCSrc), 32'd1);

      // Reserved opcode halts and flags illegal
      $display("[TB] reserved opcode");
      applyStimulus(OP_RSVD, 1'b1);
      checkCycle("rsvd_fetch", 4'd0, 8'b1101_0000);
      checkOutput("jmp_retired", 32'(retired), 32'd5);
      applyStimulus(OP_RSVD, 1'b1);
      checkCycle("rsvd_decode", 4'd1, 8'b0000_0000);
      checkOutput("rsvd_decode_illegal", 32'(illegal), 32'd0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(OP_RSVD, logic'(i % 2));
         checkCycle("halt", 4'd11, 8'b0000_0000);
         checkOutput("halt_halted", 32'(halted), 32'd1);
         checkOutput("halt_illegal", 32'(illegal), 32'd1);
      end
      checkOutput("halt_retired", 32'(retired), 32'd5);

      // Reset out of HALT, run a JUMP, then reset in the middle of MEM_WR
      $display("[TB] reset mid-store");
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst2_halted", 32'(halted), 32'd0);
      checkOutput("rst2_illegal", 32'(illegal), 32'd0);
      @(negedge CLK);
      rst_n           = 1'b1;
      input_opcode    = OP_JUMP;
      input_mem_ready = 1'b1;
      #1;
      checkCycle("rel_fetch", 4'd0, 8'b1101_0000);
      applyStimulus(OP_JUMP, 1'b1);
      applyStimulus(OP_JUMP, 1'b1);
      checkCycle("j2_exec", 4'd10, 8'b1000_0000);
      applyStimulus(OP_STORE, 1'b1);
      checkOutput("j2_retired", 32'(retired), 32'd1);
      applyStimulus(OP_STORE, 1'b0);
      applyStimulus(OP_STORE, 1'b0);
      applyStimulus(OP_STORE, 1'b0);
      checkCycle("st2_wait1", 4'd7, 8'b0010_1000);
      applyStimulus(OP_STORE, 1'b0);
      checkCycle("st2_wait2", 4'd7, 8'b0010_1000);
      #1 rst_n = 1'b0;
      #1;
      checkCycle("midrst", 4'd0, 8'b0000_0000);
      checkOutput("midrst_retired", 32'(retired), 32'd0);
      @(negedge CLK);
      rst_n           = 1'b1;
      input_mem_ready = 1'b0;
      #1;
      checkCycle("rel2_fetch", 4'd0, 8'b0001_0000);
      applyStimulus(OP_STORE, 1'b0);
      checkCycle("rel2_hold", 4'd0, 8'b0001_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
